// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_pkg
// Description : Shared constants and types for the machine-mode trap
//               sequencer. Holds the cause codes, mip bit positions,
//               mstatus field indices, mtvec modes and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    // Exception cause codes
    localparam logic [4:0] c_cause_inst_misaligned  = 5'd0;
    localparam logic [4:0] c_cause_illegal          = 5'd2;
    localparam logic [4:0] c_cause_ebreak           = 5'd3;
    localparam logic [4:0] c_cause_ecall            = 5'd11;
    localparam logic [4:0] c_cause_load_misaligned  = 5'd4;
    localparam logic [4:0] c_cause_store_misaligned = 5'd6;

    // Interrupt cause codes double as their mip/mie bit positions
    localparam int c_irq_sw_bit  = 3;
    localparam int c_irq_tim_bit = 7;
    localparam int c_irq_ext_bit = 11;

    // mstatus field indices
    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    // mtvec mode field values
    localparam logic [1:0] c_mtvec_direct   = 2'b00;
    localparam logic [1:0] c_mtvec_vectored = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_WRITE    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    typedef struct packed {
        logic inst_misaligned;
        logic illegal;
        logic ebreak;
        logic ecall;
        logic load_misaligned;
        logic store_misaligned;
    } exc_flags_t;

    // Only address/encoding faults report a value in mtval
    function automatic logic cause_has_tval(input logic [4:0] code);
        return (code == c_cause_inst_misaligned) || (code == c_cause_illegal) ||
               (code == c_cause_load_misaligned) || (code == c_cause_store_misaligned);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_controller_if
// Description : Retire-stage / CSR side bundle of the trap sequencer.
//               master : retire stage + CSR file (drives *_i, reads *_o)
//               slave  : trap_controller
// Revision    : 1.0 - initial release
// ============================================================================
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] badaddr_i;
    logic            e_inst_misaligned_i;
    logic            e_illegal_i;
    logic            e_ebreak_i;
    logic            e_ecall_i;
    logic            e_load_misaligned_i;
    logic            e_store_misaligned_i;
    logic            mret_i;
    logic            irq_ext_i;
    logic            irq_sw_i;
    logic            irq_tim_i;
    logic [XLEN-1:0] mie_i;
    logic [XLEN-1:0] mstatus_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            drained_i;
    logic            stall_o;
    logic            flush_o;
    logic            we_exc_o;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mtval_o;
    logic [XLEN-1:0] mstatus_o;
    logic [XLEN-1:0] mip_o;
    logic            redirect_o;
    logic [XLEN-1:0] target_o;

    modport master (
        output valid_i, pc_i, badaddr_i, e_inst_misaligned_i, e_illegal_i,
               e_ebreak_i, e_ecall_i, e_load_misaligned_i, e_store_misaligned_i,
               mret_i, irq_ext_i, irq_sw_i, irq_tim_i, mie_i, mstatus_i,
               mtvec_i, mepc_i, drained_i,
        input  stall_o, flush_o, we_exc_o, mcause_o, mepc_o, mtval_o,
               mstatus_o, mip_o, redirect_o, target_o
    );

    modport slave (
        input  valid_i, pc_i, badaddr_i, e_inst_misaligned_i, e_illegal_i,
               e_ebreak_i, e_ecall_i, e_load_misaligned_i, e_store_misaligned_i,
               mret_i, irq_ext_i, irq_sw_i, irq_tim_i, mie_i, mstatus_i,
               mtvec_i, mepc_i, drained_i,
        output stall_o, flush_o, we_exc_o, mcause_o, mepc_o, mtval_o,
               mstatus_o, mip_o, redirect_o, target_o
    );
endinterface
`default_nettype wire

// File: rtl/trap_prio.sv
`default_nettype none
// ============================================================================
// Module      : trap_prio
// Description : Combinational trap priority encoder. Exceptions always win;
//               interrupts are considered only when global MIE is set.
//   exc         : exception flags (already qualified by the caller)
//   irq_pending : {ext, sw, tim} pending-and-enabled interrupt bits
//   global_ie   : mstatus.MIE
//   take        : a trap must be taken
//   is_int      : the chosen trap is an interrupt
//   cause       : low cause code of the chosen trap
// Revision    : 1.0 - initial release
// ============================================================================
module trap_prio
    import trap_pkg::*;
(
    input  exc_flags_t exc,
    input  logic [2:0] irq_pending,
    input  logic       global_ie,
    output logic       take,
    output logic       is_int,
    output logic [4:0] cause
);

    always_comb begin
        take   = 1'b1;
        is_int = 1'b0;
        cause  = 5'd0;
        if (exc.inst_misaligned)       cause = c_cause_inst_misaligned;
        else if (exc.illegal)          cause = c_cause_illegal;
        else if (exc.ebreak)           cause = c_cause_ebreak;
        else if (exc.ecall)            cause = c_cause_ecall;
        else if (exc.load_misaligned)  cause = c_cause_load_misaligned;
        else if (exc.store_misaligned) cause = c_cause_store_misaligned;
        else if (global_ie && irq_pending[2]) begin
            is_int = 1'b1;
            cause  = 5'(c_irq_ext_bit);
        end else if (global_ie && irq_pending[1]) begin
            is_int = 1'b1;
            cause  = 5'(c_irq_sw_bit);
        end else if (global_ie && irq_pending[0]) begin
            is_int = 1'b1;
            cause  = 5'(c_irq_tim_bit);
        end else begin
            take = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// Module      : trap_controller
// Description : Machine-mode trap entry / mret sequencer.
//               IDLE -> DRAIN (stall, flush on entry) -> WRITE (CSR strobe)
//               -> REDIRECT (one-cycle PC redirect) -> IDLE.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : retire-stage inputs, CSR values and CSR/redirect outputs
// Revision    : 1.0 - initial release
// ============================================================================
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit VECTORED_EN = 1'b1
) (
    input  wire                clk_i,
    input  wire                rst_i,
    trap_controller_if.slave   bus
);

    state_t          r_state, w_next;
    logic            r_first_drain;
    logic            r_is_int;
    logic            r_is_mret;
    logic [4:0]      r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;

    logic [XLEN-1:0] w_mip;
    logic [2:0]      w_pend;
    logic            w_take, w_is_int, w_event;
    logic [4:0]      w_cause;
    exc_flags_t      w_exc;
    logic            w_vec_mode;
    logic [XLEN-1:0] w_base;
    logic            w_unused_mie;

    always_comb begin
        w_mip                = '0;
        w_mip[c_irq_ext_bit] = bus.irq_ext_i;
        w_mip[c_irq_sw_bit]  = bus.irq_sw_i;
        w_mip[c_irq_tim_bit] = bus.irq_tim_i;
    end

    assign w_pend = {bus.irq_ext_i & bus.mie_i[c_irq_ext_bit],
                     bus.irq_sw_i  & bus.mie_i[c_irq_sw_bit],
                     bus.irq_tim_i & bus.mie_i[c_irq_tim_bit]};
    assign w_unused_mie = ^bus.mie_i;

    assign w_exc = '{inst_misaligned:  bus.e_inst_misaligned_i,
                     illegal:          bus.e_illegal_i,
                     ebreak:           bus.e_ebreak_i,
                     ecall:            bus.e_ecall_i,
                     load_misaligned:  bus.e_load_misaligned_i,
                     store_misaligned: bus.e_store_misaligned_i};

    trap_prio u_prio (
        .exc         (w_exc),
        .irq_pending (w_pend),
        .global_ie   (bus.mstatus_i[c_mstatus_mie]),
        .take        (w_take),
        .is_int      (w_is_int),
        .cause       (w_cause)
    );

    assign w_base = {bus.mtvec_i[XLEN-1:2], 2'b00};

    generate
        if (VECTORED_EN) begin : g_vectored
            assign w_vec_mode = (bus.mtvec_i[1:0] == c_mtvec_vectored);
        end else begin : g_direct
            assign w_vec_mode = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_first_drain <= 1'b0;
            r_is_int      <= 1'b0;
            r_is_mret     <= 1'b0;
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
        end else begin
            r_state       <= w_next;
            r_first_drain <= w_event;
            if (w_event) begin
                r_is_mret <= !w_take;
                // mret leaves the trap record alone so WRITE echoes it
                if (w_take) begin
                    r_is_int <= w_is_int;
                    r_cause  <= w_cause;
                    r_epc    <= bus.pc_i;
                    r_tval   <= (!w_is_int && cause_has_tval(w_cause)) ? bus.badaddr_i : '0;
                end
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_event        = 1'b0;
        bus.stall_o    = 1'b0;
        bus.flush_o    = 1'b0;
        bus.we_exc_o   = 1'b0;
        bus.mcause_o   = '0;
        bus.mepc_o     = '0;
        bus.mtval_o    = '0;
        bus.mstatus_o  = '0;
        bus.mip_o      = '0;
        bus.redirect_o = 1'b0;
        bus.target_o   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.valid_i && (w_take || bus.mret_i)) begin
                    w_event = 1'b1;
                    w_next  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.stall_o = 1'b1;
                bus.flush_o = r_first_drain;
                if (bus.drained_i) w_next = S_WRITE;
            end
            S_WRITE: begin
                bus.stall_o            = 1'b1;
                bus.we_exc_o           = 1'b1;
                bus.mip_o              = w_mip;
                bus.mcause_o[XLEN-1]   = r_is_int;
                bus.mcause_o[4:0]      = r_cause;
                bus.mtval_o            = r_tval;
                bus.mstatus_o          = bus.mstatus_i;
                if (r_is_mret) begin
                    bus.mepc_o                       = bus.mepc_i;
                    bus.mstatus_o[c_mstatus_mie]     = bus.mstatus_i[c_mstatus_mpie];
                    bus.mstatus_o[c_mstatus_mpie]    = 1'b1;
                end else begin
                    bus.mepc_o                       = r_epc;
                    bus.mstatus_o[c_mstatus_mpie]    = bus.mstatus_i[c_mstatus_mie];
                    bus.mstatus_o[c_mstatus_mie]     = 1'b0;
                    bus.mstatus_o[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
                end
                w_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                bus.redirect_o = 1'b1;
                if (r_is_mret)                    bus.target_o = bus.mepc_i;
                else if (r_is_int && w_vec_mode)  bus.target_o = w_base + {{(XLEN-7){1'b0}}, r_cause, 2'b00};
                else                              bus.target_o = w_base;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/trap_controller.md
# trap_controller

Sequencer for machine-mode trap entry and `mret` return. It sits between the pipeline's retire stage and the `csr` register file. It picks the highest-priority exception or enabled interrupt, drains the pipeline, and drives the `csr` exception write port (`mepc`/`mcause`/`mtval`/`mstatus`). It then issues a single PC redirect to the trap vector or to `mepc`.

## Interface
Reset is synchronous, active-high (`rst_i`), on the single clock `clk_i`.

Parameters:
- `XLEN`, 32, datapath width.
- `VECTORED_EN`, 1, honour `mtvec[1:0]==01` vectored mode for interrupts; 0 = always direct.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `valid_i` in 1: retire stage holds a valid instruction this cycle.
- `pc_i` in XLEN: PC of the retiring instruction.
- `badaddr_i` in XLEN: faulting address or instruction bits for `mtval`.
- `e_inst_misaligned_i`, `e_illegal_i`, `e_ebreak_i`, `e_ecall_i`, `e_load_misaligned_i`, `e_store_misaligned_i` in 1 each: exception flags, qualified by `valid_i`.
- `mret_i` in 1: retiring instruction is `mret`.
- `irq_ext_i`, `irq_sw_i`, `irq_tim_i` in 1 each: level interrupt lines, become `mip` bits 11/3/7.
- `mie_i` in XLEN: current `mie` CSR.
- `mstatus_i` in XLEN: current `mstatus` (MIE bit 3, MPIE bit 7).
- `mtvec_i`, `mepc_i` in XLEN: current CSR values.
- `drained_i` in 1: pipeline empty after flush.
- `stall_o` out 1: hold fetch/retire; reset 0.
- `flush_o` out 1: kill younger instructions; reset 0.
- `we_exc_o` out 1: one-cycle `csr` exception write strobe; reset 0.
- `mcause_o`, `mepc_o`, `mtval_o`, `mstatus_o`, `mip_o` out XLEN: `csr` write data; reset 0.
- `redirect_o` out 1: one-cycle PC redirect; reset 0.
- `target_o` out XLEN: redirect target; reset 0.

## Operation
- FSM states: IDLE, DRAIN, WRITE, REDIRECT.
- IDLE: each cycle with `valid_i=1`, evaluate events in this order:
  - Any exception flag: take an exception.
  - Otherwise, if `mstatus_i[3]` and `(mip & mie_i) != 0`: take an interrupt.
  - Otherwise, if `mret_i`: take a return.
  - Otherwise, stay in IDLE.
- Exception priority and `mcause` codes: inst-misaligned 0 > illegal 2 > ebreak 3 > ecall 11 > load-misaligned 4 > store-misaligned 6.
- Interrupt priority and `mcause` codes: ext 11 > sw 3 > tim 7; `mcause[31]=1`.
- Latch at event: the cause; `mepc = pc_i` (exception/mret) or `pc_i` of the next unexecuted instruction (interrupt, i.e. retiring instruction is not executed); `mtval = badaddr_i` for codes 0/2/4/6, else 0.
- Transition to DRAIN with `stall_o=1` and `flush_o=1` for the DRAIN entry cycle.
- DRAIN: `stall_o=1`; wait for `drained_i`, then go to WRITE.
- WRITE, trap: `we_exc_o=1`; `mstatus_o` = `mstatus_i` with MPIE←MIE, MIE←0, MPP←2'b11; `mip_o` = current `mip`.
- WRITE, mret: `we_exc_o=1` with `mepc_o`/`mcause_o`/`mtval_o` unchanged (echo the CSR values); `mstatus_o` with MIE←MPIE, MPIE←1.
- REDIRECT: `redirect_o=1` for one cycle, then return to IDLE; `stall_o` drops in the same cycle.
  - Trap target: `{mtvec_i[XLEN-1:2],2'b00}`.
  - Vectored interrupt target (when `VECTORED_EN` and `mtvec_i[1:0]==01`): base + 4·(cause & 0x1F).
  - Mret target: `mepc_i`.

## Timing
- Event in IDLE at cycle N. If `drained_i` is already high at N+1, then WRITE is at N+2 and REDIRECT at N+3 (minimum 3-cycle latency).
- Events arriving outside IDLE are ignored. The pipeline is stalled, so none should arrive.
- Simultaneous exception and interrupt: the exception wins and the interrupt is re-evaluated after return. Simultaneous `mret` and exception flag: the exception wins.
- Interrupts are level-sensitive. A deasserted line before IDLE sampling means no trap.
- `rst_i` in any state: next cycle is IDLE with all outputs 0. No partial CSR write.

## Structure
- Package `trap_pkg`:
  - Cause-code constants and interrupt bit positions (3/7/11).
  - `mstatus` field indices (MIE=3, MPIE=7, MPP=12:11).
  - FSM state enum.
  - `mtvec` mode constants.
- Sub-module `trap_prio`: combinational priority encoder taking flags, `mip & mie`, and global MIE; outputs take, is_int, and cause.

## Test plan
- Illegal at `pc_i=0x100`, `badaddr_i=0x00000FFF`, `mtvec_i=0x200`, `drained_i=1` → `we_exc_o` with `mcause=2`, `mepc=0x100`, `mtval=0xFFF`; `redirect_o` to 0x200 at N+3.
- `irq_tim_i=1`, `mie_i[7]=1`, `mstatus_i=0x8`, `mtvec_i=0x201` → `mcause=0x80000007`, `mstatus_o` MIE=0/MPIE=1/MPP=11, target 0x21C.
- Same setup with `mstatus_i[3]=0` → no trap, `stall_o` stays 0.
- `e_ecall_i` and `irq_ext_i` together → `mcause=11` (exception wins).
- `mret_i`, `mepc_i=0x400`, `mstatus_i=0x80` → `mstatus_o[3]=1`, target 0x400.
- `drained_i` held low 5 cycles, then `rst_i` pulsed → FSM in IDLE, all outputs 0, no `we_exc_o` ever asserted.
